ram_stream_ctrl: RTL

- Initiator that drives the port side of a single-port read-first RAM (enable, write_en, reset, address, data_in, with registered data_out).
- Converts three block-level commands into RAM accesses:
  - LOAD: a valid/ready input stream is written to consecutive RAM words.
  - UNLOAD: consecutive RAM words are read out as a valid/ready output stream.
  - CLEAR: consecutive RAM words are zero-filled.
- Sits between the polynomial/coefficient datapaths and each coefficient RAM instance.

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/ram_ctrl_skid_fifo.sv | 54 +++++
 rtl/ram_stream_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared command and state types for the RAM stream controller.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_UNLOAD = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_RSVD   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UNLOAD = 2'd2,
    CLEAR  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_ctrl_skid_fifo.sv
// Two-entry synchronous FIFO buffering RAM read data for the UNLOAD stream.
module ram_ctrl_skid_fifo #(
  parameter int unsigned MEM_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [MEM_WIDTH-1:0] push_data,
  input  logic                 pop,
  output logic                 out_valid,
  output logic [MEM_WIDTH-1:0] out_data,
  output logic [1:0]           count
);

  logic [MEM_WIDTH-1:0] data_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic                 do_push, do_pop;

  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
  end

  // Storage and pointer registers; storage clears so out_data reads 0 after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (do_push) data_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/ram_stream_ctrl.sv
// Drives a single-port read-first RAM: streams words in (LOAD), out (UNLOAD) or zero-fills (CLEAR).
module ram_stream_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MEM_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MEM_WIDTH-1:0] out_data,
  output logic                 mem_enable,
  output logic                 mem_write_en,
  output logic                 mem_reset,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [MEM_WIDTH-1:0] mem_data_in,
  input  logic [MEM_WIDTH-1:0] mem_data_out
);

  localparam int unsigned        LEN_W     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [LEN_W-1:0]   DEPTH_LEN = LEN_W'(MEM_DEPTH);
  localparam logic [LEN_W-1:0]   ONE_LEN   = LEN_W'(1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   issue_left_q, issue_left_d;  // RAM accesses still to issue
  logic [LEN_W-1:0]   out_left_q, out_left_d;      // UNLOAD words still to hand out
  logic               inflight_q;                  // read issued last cycle, data on mem_data_out now
  logic               done_q, done_d;

  op_t                cmd_op;
  logic [LEN_W-1:0]   eff_len;
  logic               fifo_valid;
  logic [MEM_WIDTH-1:0] fifo_data;
  logic [1:0]         fifo_count;
  logic               pop;
  logic               issue_rd;
  logic               access;
  logic [2:0]         occupancy;

  assign cmd_op  = op_t'(op);
  assign eff_len = (length > DEPTH_LEN) ? DEPTH_LEN : length;
  assign pop     = fifo_valid && out_ready;

  // Words that will be buffered or in flight after this cycle if no new read is issued.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue_rd  = (state_q == UNLOAD) && (issue_left_q != '0) && (occupancy < 3'd2);

  // Command decode, RAM port drive and next-state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    done_d       = 1'b0;
    in_ready     = 1'b0;
    mem_enable   = 1'b0;
    mem_write_en = 1'b0;
    mem_data_in  = '0;
    access       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && (cmd_op != OP_RSVD)) begin
          if (eff_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d       = base_addr;
            issue_left_d = eff_len;
            out_left_d   = eff_len;
            unique case (cmd_op)
              OP_LOAD:   state_d = LOAD;
              OP_UNLOAD: state_d = UNLOAD;
              default:   state_d = CLEAR;
            endcase
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_enable   = 1'b1;
          mem_write_en = 1'b1;
          mem_data_in  = in_data;
          access       = 1'b1;
        end
      end
      CLEAR: begin
        mem_enable   = 1'b1;
        mem_write_en = 1'b1;
        access       = 1'b1;
      end
      UNLOAD: begin
        if (issue_rd) begin
          mem_enable = 1'b1;
          access     = 1'b1;
        end
        // UNLOAD finishes on the last output handshake, not the last read.
        if (pop) begin
          out_left_d = out_left_q - ONE_LEN;
          if (out_left_q == ONE_LEN) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (access) begin
      addr_d       = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      issue_left_d = issue_left_q - ONE_LEN;
      if ((state_q != UNLOAD) && (issue_left_q == ONE_LEN)) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= issue_rd;
      done_q       <= done_d;
    end
  end

  ram_ctrl_skid_fifo #(
    .MEM_WIDTH (MEM_WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (mem_data_out),
    .pop       (pop),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign out_valid   = fifo_valid;
  assign out_data    = fifo_data;
  assign mem_address = addr_q;
  assign mem_reset   = 1'b0;

endmodule
